// File: rtl/affichage_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment display driver.
// Segment patterns are active low, bit order [6:0] = g..a.
package affichage_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] ANODE_OFF      = 3'b111;
  localparam logic [2:0] ANODE_UNITS    = 3'b110;
  localparam logic [2:0] ANODE_TENS     = 3'b101;
  localparam logic [2:0] ANODE_HUNDREDS = 3'b011;

  typedef enum logic [1:0] {
    SlotUnits    = 2'd0,
    SlotTens     = 2'd1,
    SlotHundreds = 2'd2
  } slot_e;

endpackage

// File: rtl/decodeur_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module decodeur_7seg
  import affichage_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/affichage_multiplexe.sv
// Time-multiplexed 3-digit 7-segment driver with leading-zero blanking, frame-aligned
// input capture and whole-display blinking. All pad outputs are registered.
module affichage_multiplexe
  import affichage_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned SCAN_HZ  = 1_000,
  parameter int unsigned BLINK_FR = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd100,
  input  logic [3:0] bcd10,
  input  logic [3:0] bcd1,
  input  logic       en100,
  input  logic       en10,
  input  logic       blink,
  output logic [2:0] anodes,
  output logic [6:0] segments,
  output logic       frame_tick
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned BW  = $clog2(2 * BLINK_FR);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(2 * BLINK_FR - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FR);

  logic [PW-1:0] presc_q, presc_d;
  slot_e         idx_q, idx_d;
  logic [3:0]    bcd100_q, bcd100_d, bcd10_q, bcd10_d, bcd1_q, bcd1_d;
  logic          en100_q, en100_d, en10_q, en10_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          off_q, off_d;
  logic [2:0]    anodes_q, anodes_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  logic       tick, capture;
  logic [3:0] digit;
  logic [6:0] seg_dec;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    capture = tick && (idx_q == SlotHundreds);
    presc_d = tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      case (idx_q)
        SlotUnits: idx_d = SlotTens;
        SlotTens:  idx_d = SlotHundreds;
        default:   idx_d = SlotUnits;
      endcase
    end

    bcd100_d     = bcd100_q;
    bcd10_d      = bcd10_q;
    bcd1_d       = bcd1_q;
    en100_d      = en100_q;
    en10_d       = en10_q;
    off_d        = off_q;
    frame_tick_d = capture;
    if (capture) begin
      bcd100_d = bcd100;
      bcd10_d  = bcd10;
      bcd1_d   = bcd1;
      en100_d  = en100;
      en10_d   = en10;
      // Phase is latched per frame so every slot of a frame shares one on/off state.
      off_d    = blink && (blink_cnt_q >= BLINK_HALF);
    end

    blink_cnt_d = blink_cnt_q;
    if (!blink) begin
      blink_cnt_d = '0;
    end else if (capture) begin
      blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
    end
  end

  // Next-state shadow values feed the decoder so a fresh capture shows in the units slot at once.
  always_comb begin
    digit = bcd1_d;
    case (idx_d)
      SlotTens:     digit = bcd10_d;
      SlotHundreds: digit = bcd100_d;
      default:      digit = bcd1_d;
    endcase
  end

  decodeur_7seg u_decodeur (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_comb begin
    logic       show;
    logic [2:0] anode_sel;
    show      = 1'b1;
    anode_sel = ANODE_UNITS;
    anodes_d  = anodes_q;
    seg_d     = seg_q;
    case (idx_d)
      SlotTens: begin
        show      = en10_d || en100_d;
        anode_sel = ANODE_TENS;
      end
      SlotHundreds: begin
        show      = en100_d;
        anode_sel = ANODE_HUNDREDS;
      end
      default: begin
        show      = 1'b1;
        anode_sel = ANODE_UNITS;
      end
    endcase
    if (tick) begin
      if (show && !off_d) begin
        anodes_d = anode_sel;
        seg_d    = seg_dec;
      end else begin
        anodes_d = ANODE_OFF;
        seg_d    = SEG_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= SlotUnits;
      bcd100_q     <= '0;
      bcd10_q      <= '0;
      bcd1_q       <= '0;
      en100_q      <= 1'b0;
      en10_q       <= 1'b0;
      blink_cnt_q  <= '0;
      off_q        <= 1'b0;
      anodes_q     <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      bcd100_q     <= bcd100_d;
      bcd10_q      <= bcd10_d;
      bcd1_q       <= bcd1_d;
      en100_q      <= en100_d;
      en10_q       <= en10_d;
      blink_cnt_q  <= blink_cnt_d;
      off_q        <= off_d;
      anodes_q     <= anodes_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anodes     = anodes_q;
  assign segments   = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_affichage_multiplexe.sv
// Directed bench for affichage_multiplexe with DIV=4 (12-clock frames) and BLINK_FR=2.
module tb_affichage_multiplexe;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd100, bcd10, bcd1;
  logic       en100, en10, blink;
  logic [2:0] anodes;
  logic [6:0] segments;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  affichage_multiplexe #(
    .CLK_HZ   (8),
    .SCAN_HZ  (2),
    .BLINK_FR (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd100     (bcd100),
    .bcd10      (bcd10),
    .bcd1       (bcd1),
    .en100      (en100),
    .en10       (en10),
    .blink      (blink),
    .anodes     (anodes),
    .segments   (segments),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Waits (bounded) for frame_tick, sampled on the falling edge.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 30);
    check({tag, "_tick"}, 16'(frame_tick), 16'd1);
  endtask

  task automatic set_val(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         input logic eh, input logic et);
    bcd100 = h;
    bcd10  = t;
    bcd1   = u;
    en100  = eh;
    en10   = et;
  endtask

  // Checks one full frame: slot0 at the tick, then slot1 and slot2 four clocks apart.
  task automatic check_frame(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                             input logic [9:0] e2);
    wait_frame(tag);
    check({tag, "_s0"}, 16'({anodes, segments}), 16'(e0));
    repeat (4) @(negedge clk);
    check({tag, "_s1"}, 16'({anodes, segments}), 16'(e1));
    repeat (4) @(negedge clk);
    check({tag, "_s2"}, 16'({anodes, segments}), 16'(e2));
  endtask

  localparam logic [9:0] BLANK = {3'b111, 7'b1111111};

  initial begin
    int n;
    rst_n = 1'b0;
    blink = 1'b0;
    set_val(4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    #23;
    check("rst_anodes", 16'(anodes), 16'h0007);
    check("rst_segments", 16'(segments), 16'h007f);
    check("rst_frame_tick", 16'(frame_tick), 16'd0);

    // First capture lands on the third tick: 12 clocks after release.
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frame_tick && n < 12)
        check("pre_capture_blank", 16'({anodes, segments}), 16'(BLANK));
    end while (!frame_tick && n < 30);
    check("first_capture_latency", 16'(n), 16'd12);
    check("val7_f1_s0", 16'({anodes, segments}), 16'({3'b110, 7'b1111000}));
    @(negedge clk);
    check("frame_tick_width", 16'(frame_tick), 16'd0);

    check_frame("val7", {3'b110, 7'b1111000}, BLANK, BLANK);

    set_val(4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    check_frame("val123", {3'b110, 7'b0110000}, {3'b101, 7'b0100100}, {3'b011, 7'b1111001});
    check_frame("val123b", {3'b110, 7'b0110000}, {3'b101, 7'b0100100}, {3'b011, 7'b1111001});

    // Mid-frame change must stay invisible until the next capture.
    wait_frame("tear");
    check("tear_s0", 16'({anodes, segments}), 16'({3'b110, 7'b0110000}));
    set_val(4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("tear_s1", 16'({anodes, segments}), 16'({3'b101, 7'b0100100}));
    repeat (4) @(negedge clk);
    check("tear_s2", 16'({anodes, segments}), 16'({3'b011, 7'b1111001}));
    check_frame("val5", {3'b110, 7'b0010010}, BLANK, BLANK);

    set_val(4'd0, 4'd0, 4'd12, 1'b0, 1'b0);
    check_frame("dash", {3'b110, 7'b0111111}, BLANK, BLANK);

    set_val(4'd0, 4'd9, 4'd0, 1'b0, 1'b1);
    check_frame("val90", {3'b110, 7'b1000000}, {3'b101, 7'b0010000}, BLANK);

    // en100 without en10 forces the tens zero to show.
    set_val(4'd1, 4'd0, 4'd4, 1'b1, 1'b0);
    check_frame("val104", {3'b110, 7'b0011001}, {3'b101, 7'b1000000}, {3'b011, 7'b1111001});

    set_val(4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    check_frame("pre_blink", {3'b110, 7'b1111000}, BLANK, BLANK);
    blink = 1'b1;
    check_frame("blink_on1", {3'b110, 7'b1111000}, BLANK, BLANK);
    check_frame("blink_on2", {3'b110, 7'b1111000}, BLANK, BLANK);
    check_frame("blink_off1", BLANK, BLANK, BLANK);
    check_frame("blink_off2", BLANK, BLANK, BLANK);
    check_frame("blink_on3", {3'b110, 7'b1111000}, BLANK, BLANK);
    blink = 1'b0;
    check_frame("noblink1", {3'b110, 7'b1111000}, BLANK, BLANK);
    check_frame("noblink2", {3'b110, 7'b1111000}, BLANK, BLANK);

    // Asynchronous reset mid-frame blanks at once and restarts the scan.
    set_val(4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    check_frame("pre_rst", {3'b110, 7'b0110000}, {3'b101, 7'b0100100}, {3'b011, 7'b1111001});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_blank", 16'({anodes, segments}), 16'(BLANK));
    check("midrst_frame_tick", 16'(frame_tick), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 30);
    check("midrst_latency", 16'(n), 16'd12);
    check("midrst_s0", 16'({anodes, segments}), 16'({3'b110, 7'b0110000}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
